jtcop_mcu_bridge: RTL and testbench

- Parametrised bridge between the 68000-side main CPU and a HuC6280-class protection/sound MCU.
- Provides a shared RAM window with main-priority arbitration, CH doorbell interrupt channels in each direction, and an MCU ROM fetch handshake to SDRAM with wait-state generation.
- One instance per board variant; window size and channel count are set per game.

---
 rtl/jtcop_mcu_bridge.sv | 208 ++++++++++++++++++++
 tb/tb_jtcop_mcu_bridge.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/jtcop_mcu_bridge.sv
// Main CPU / MCU bridge: shared RAM window, doorbell IRQs, ROM fetch.
// Define JTCOP_BRIDGE_LUT_EN to add the protection key LUT.
module jtcop_mcu_bridge #(
  parameter int         AW      = 11,
  parameter int         CH      = 2,
  parameter logic [7:0] IRQ_LEN = 8'd255,
  parameter int         RAW     = 16
) (
  input  logic           rst,
  input  logic           clk,
  input  logic [AW-1:0]  main_addr,
  input  logic [7:0]     main_dout,
  output logic [7:0]     main_din,
  input  logic           main_cs,
  input  logic           main_wrn,
  output logic [CH-1:0]  main_irqn,
  input  logic [AW-1:0]  mcu_addr,
  input  logic [7:0]     mcu_dout,
  output logic [7:0]     mcu_din,
  input  logic           mcu_ram_cs,
  input  logic           mcu_rom_cs,
  input  logic [RAW-1:0] mcu_rom_addr,
  input  logic           mcu_wrn,
  output logic           mcu_waitn,
  output logic [CH-1:0]  mcu_irqn,
  output logic [RAW-1:0] rom_addr,
  output logic           rom_cs,
  input  logic [7:0]     rom_data,
  input  logic           rom_ok
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } rom_st_t;

  localparam logic [AW-1:0] TOP = AW'((2**AW) - 1);

  logic [7:0]    ram [2**AW];
  logic          mcu_gnt;
  logic [AW-1:0] port_addr;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic [7:0]    rd_data;
  logic [7:0]    mcu_rd;
  logic          mcu_ram_wr;
  logic          main_rd;
  logic          main_wr;
  logic          mcu_rd_gnt;

  logic [CH-1:0]      main_db;
  logic [CH-1:0]      mcu_db;
  logic [CH-1:0]      flag;
  logic [CH-1:0][7:0] cnt;

  rom_st_t st;
  rom_st_t st_nxt;
  logic    first;
  logic    rom_load;
  logic    rom_done;
  logic    rom_wait;
  logic    ram_wait;

  // ROM access wins over a (illegal) simultaneous RAM strobe
  assign mcu_gnt    = !main_cs && mcu_ram_cs && !mcu_rom_cs;
  assign mcu_rd_gnt = mcu_gnt && mcu_wrn;
  assign main_rd    = main_cs && main_wrn;
  assign main_wr    = main_cs && !main_wrn;
  assign port_addr  = main_cs ? main_addr : mcu_addr;
  assign wr_data    = main_cs ? main_dout : mcu_dout;
  assign wr_en      = main_wr || mcu_ram_wr;
  assign rd_data    = ram[port_addr];

`ifdef JTCOP_BRIDGE_LUT_EN
  localparam logic [AW-1:0] KEY_A = AW'((2**AW) - 1 - CH);

  logic [7:0] key;
  logic [7:0] lut_val;
  logic       key_hit;

  assign key_hit    = mcu_gnt && (mcu_addr == KEY_A);
  assign mcu_ram_wr = mcu_gnt && !mcu_wrn && !key_hit;
  assign mcu_rd     = key_hit ? lut_val : rd_data;

  always_comb begin
    unique case (key)
      8'h45:   lut_val = 8'h4E;
      8'h92:   lut_val = 8'h15;
      default: lut_val = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key <= 8'h00;
    end else if (key_hit && !mcu_wrn) begin
      key <= mcu_dout;
    end
  end
`else
  assign mcu_ram_wr = mcu_gnt && !mcu_wrn;
  assign mcu_rd     = rd_data;
`endif

  always_ff @(posedge clk) begin
    if (wr_en) begin
      ram[port_addr] <= wr_data;
    end
  end

  always_comb begin
    for (int k = 0; k < CH; k++) begin
      main_db[k]  = main_addr == (TOP - AW'(k));
      mcu_db[k]   = mcu_addr == (TOP - AW'(k));
      mcu_irqn[k] = cnt[k] == 8'd0;
    end
  end

  assign main_irqn = ~flag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_din <= 8'h00;
      mcu_din  <= 8'hFF;
      flag     <= '0;
      cnt      <= '0;
    end else begin
      if (main_rd) begin
        main_din <= rd_data;
      end
      if (rom_done) begin
        mcu_din <= rom_data;
      end else if (mcu_rd_gnt) begin
        mcu_din <= mcu_rd;
      end
      for (int k = 0; k < CH; k++) begin
        if (main_wr && main_db[k]) begin
          cnt[k] <= IRQ_LEN;
        end else if (mcu_rd_gnt && mcu_db[k]) begin
          cnt[k] <= 8'd0;
        end else if (cnt[k] != 8'd0) begin
          cnt[k] <= cnt[k] - 8'd1;
        end
        if (mcu_ram_wr && mcu_db[k]) begin
          flag[k] <= 1'b1;
        end else if (main_rd && main_db[k]) begin
          flag[k] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    st_nxt   = st;
    rom_load = 1'b0;
    rom_done = 1'b0;
    rom_wait = 1'b0;
    unique case (st)
      IDLE: begin
        if (mcu_rom_cs) begin
          rom_load = 1'b1;
          rom_wait = 1'b1;
          st_nxt   = REQ;
        end
      end
      REQ: begin
        rom_wait = 1'b1;
        // rom_ok seen on the entry cycle belongs to a previous request
        if (!first && rom_ok) begin
          rom_done = 1'b1;
          st_nxt   = DONE;
        end
      end
      DONE: begin
        if (!mcu_rom_cs) begin
          st_nxt = IDLE;
        end else if (mcu_rom_addr != rom_addr) begin
          rom_load = 1'b1;
          st_nxt   = REQ;
        end
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= IDLE;
      first    <= 1'b0;
      rom_cs   <= 1'b0;
      rom_addr <= '0;
    end else begin
      st    <= st_nxt;
      first <= rom_load;
      if (rom_load) begin
        rom_cs   <= 1'b1;
        rom_addr <= mcu_rom_addr;
      end else if (rom_done) begin
        rom_cs <= 1'b0;
      end
    end
  end

  assign ram_wait  = main_cs && mcu_ram_cs;
  assign mcu_waitn = rst || !(rom_wait || ram_wait);

endmodule

// File: tb/tb_jtcop_mcu_bridge.sv
// Directed bench for jtcop_mcu_bridge; LUT steps run when
// JTCOP_BRIDGE_LUT_EN is defined.
module tb_jtcop_mcu_bridge;

  localparam int AW  = 11;
  localparam int CH  = 2;
  localparam int RAW = 16;

  logic           rst;
  logic           clk;
  logic [AW-1:0]  main_addr;
  logic [7:0]     main_dout;
  logic [7:0]     main_din;
  logic           main_cs;
  logic           main_wrn;
  logic [CH-1:0]  main_irqn;
  logic [AW-1:0]  mcu_addr;
  logic [7:0]     mcu_dout;
  logic [7:0]     mcu_din;
  logic           mcu_ram_cs;
  logic           mcu_rom_cs;
  logic [RAW-1:0] mcu_rom_addr;
  logic           mcu_wrn;
  logic           mcu_waitn;
  logic [CH-1:0]  mcu_irqn;
  logic [RAW-1:0] rom_addr;
  logic           rom_cs;
  logic [7:0]     rom_data;
  logic           rom_ok;

  int total = 0;
  int bad   = 0;
  int n;
  int lowcnt;
  int viol;

  jtcop_mcu_bridge #(
    .AW(AW), .CH(CH), .IRQ_LEN(8'd255), .RAW(RAW)
  ) dut (
    .rst(rst), .clk(clk),
    .main_addr(main_addr), .main_dout(main_dout),
    .main_din(main_din), .main_cs(main_cs),
    .main_wrn(main_wrn), .main_irqn(main_irqn),
    .mcu_addr(mcu_addr), .mcu_dout(mcu_dout),
    .mcu_din(mcu_din), .mcu_ram_cs(mcu_ram_cs),
    .mcu_rom_cs(mcu_rom_cs), .mcu_rom_addr(mcu_rom_addr),
    .mcu_wrn(mcu_wrn), .mcu_waitn(mcu_waitn),
    .mcu_irqn(mcu_irqn), .rom_addr(rom_addr),
    .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    main_addr = '0; main_dout = 8'h00; main_cs = 1'b0; main_wrn = 1'b1;
    mcu_addr = '0; mcu_dout = 8'h00; mcu_ram_cs = 1'b0; mcu_wrn = 1'b1;
    mcu_rom_cs = 1'b0; mcu_rom_addr = '0;
    rom_data = 8'h00; rom_ok = 1'b0;
    tick(); tick();
    chk("rst_main_din", 32'(main_din), 32'h00);
    chk("rst_mcu_din", 32'(mcu_din), 32'hFF);
    chk("rst_main_irqn", 32'(main_irqn), 32'h3);
    chk("rst_mcu_irqn", 32'(mcu_irqn), 32'h3);
    chk("rst_waitn", 32'(mcu_waitn), 32'h1);
    chk("rst_rom_cs", 32'(rom_cs), 32'h0);
    chk("rst_rom_addr", 32'(rom_addr), 32'h0);
    rst = 1'b0;
    tick();

    main_cs = 1'b1; main_wrn = 1'b0;
    main_addr = 11'h010; main_dout = 8'h5A;
    tick();
    main_cs = 1'b0; main_wrn = 1'b1;
    mcu_ram_cs = 1'b1; mcu_addr = 11'h010;
    #1;
    chk("rd_pre_grant", 32'(mcu_din), 32'hFF);
    tick();
    chk("rd_mcu_010", 32'(mcu_din), 32'h5A);
    mcu_ram_cs = 1'b0;
    main_cs = 1'b1; main_addr = 11'h010;
    tick();
    chk("rd_main_010", 32'(main_din), 32'h5A);

    main_wrn = 1'b0; main_addr = 11'h020; main_dout = 8'hA7;
    tick();
    main_wrn = 1'b1; main_addr = 11'h030;
    mcu_ram_cs = 1'b1; mcu_addr = 11'h020;
    lowcnt = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (!mcu_waitn) lowcnt++;
      tick();
    end
    main_cs = 1'b0;
    #1;
    chk("arb_wait_cycles", 32'(lowcnt), 32'd3);
    chk("arb_waitn_free", 32'(mcu_waitn), 32'h1);
    chk("arb_din_held", 32'(mcu_din), 32'h5A);
    tick();
    chk("arb_rd_data", 32'(mcu_din), 32'hA7);
    mcu_ram_cs = 1'b0;

    main_cs = 1'b1; main_wrn = 1'b0;
    main_addr = 11'h7FF; main_dout = 8'h11;
    tick();
    main_cs = 1'b0; main_wrn = 1'b1;
    chk("db0_irq_on", 32'(mcu_irqn), 32'h2);
    n = 0; viol = 0;
    while (mcu_irqn[0] == 1'b0 && n < 300) begin
      if (!mcu_irqn[1] || main_irqn != 2'b11) viol++;
      n++;
      tick();
    end
    chk("db0_hold_len", 32'(n), 32'd255);
    chk("db0_irq_off", 32'(mcu_irqn), 32'h3);
    chk("db0_side_bits", 32'(viol), 32'd0);

    main_cs = 1'b1; main_wrn = 1'b0;
    main_addr = 11'h7FF; main_dout = 8'h22;
    tick();
    main_cs = 1'b0; main_wrn = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    mcu_ram_cs = 1'b1; mcu_addr = 11'h7FF;
    #1;
    chk("ack_pre", 32'(mcu_irqn), 32'h2);
    tick();
    mcu_ram_cs = 1'b0;
    chk("ack_irq_off", 32'(mcu_irqn), 32'h3);
    chk("ack_db_data", 32'(mcu_din), 32'h22);

    mcu_ram_cs = 1'b1; mcu_wrn = 1'b0;
    mcu_addr = 11'h7FE; mcu_dout = 8'h3C;
    tick();
    mcu_ram_cs = 1'b0; mcu_wrn = 1'b1;
    chk("db1_main_irq", 32'(main_irqn), 32'h1);
    chk("db1_mcu_irq", 32'(mcu_irqn), 32'h3);
    main_cs = 1'b1; main_addr = 11'h7FE;
    tick();
    main_cs = 1'b0;
    chk("db1_clear", 32'(main_irqn), 32'h3);
    chk("db1_data", 32'(main_din), 32'h3C);

    mcu_rom_cs = 1'b1; mcu_rom_addr = 16'h1234;
    lowcnt = 0;
    for (int i = 0; i < 40; i++) begin
      rom_ok = (i < 2) || (i >= 5);
      rom_data = (i < 5) ? 8'h99 : 8'hC3;
      #1;
      if (i == 3) chk("rom_cs_req", 32'(rom_cs), 32'h1);
      if (mcu_waitn) break;
      lowcnt++;
      tick();
    end
    chk("rom_wait_cycles", 32'(lowcnt), 32'd6);
    chk("rom_addr", 32'(rom_addr), 32'h1234);
    chk("rom_data", 32'(mcu_din), 32'hC3);
    chk("rom_cs_done", 32'(rom_cs), 32'h0);
    mcu_rom_cs = 1'b0; rom_ok = 1'b0;
    tick();
    chk("rom_idle_waitn", 32'(mcu_waitn), 32'h1);

    mcu_rom_cs = 1'b1; mcu_rom_addr = 16'h0ABC;
    tick();
    chk("rst_req_cs", 32'(rom_cs), 32'h1);
    chk("rst_req_wait", 32'(mcu_waitn), 32'h0);
    rst = 1'b1;
    #1;
    chk("rst_mid_cs", 32'(rom_cs), 32'h0);
    chk("rst_mid_waitn", 32'(mcu_waitn), 32'h1);
    chk("rst_mid_addr", 32'(rom_addr), 32'h0);
    chk("rst_mid_din", 32'(mcu_din), 32'hFF);
    mcu_rom_cs = 1'b0;
    tick();
    rst = 1'b0;
    tick();

`ifdef JTCOP_BRIDGE_LUT_EN
    mcu_addr = 11'h7FD;
    mcu_ram_cs = 1'b1; mcu_wrn = 1'b0; mcu_dout = 8'h45;
    tick();
    mcu_wrn = 1'b1;
    tick();
    chk("lut_45", 32'(mcu_din), 32'h4E);
    mcu_wrn = 1'b0; mcu_dout = 8'h92;
    tick();
    mcu_wrn = 1'b1;
    tick();
    chk("lut_92", 32'(mcu_din), 32'h15);
    mcu_wrn = 1'b0; mcu_dout = 8'h00;
    tick();
    mcu_wrn = 1'b1;
    tick();
    chk("lut_00", 32'(mcu_din), 32'h00);
    mcu_ram_cs = 1'b0;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
